div_pipelined_collector: RTL
============================

Name: div_pipelined_collector

Overview:
- Tail stage of the pipelined divider; the consumer end of the valid/busy latch chain.
- Takes the last latch's sign flag, original operands and raw magnitude quotient/remainder.
- Applies signed-result correction and the divide-by-zero rule, then buffers results in a small FIFO.
- Presents results to the execute writeback with a valid/busy handshake, and drives busy back up the pipeline.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, >=2.
- PTR_W, 1, pointer width, equal to log2(DEPTH).

Ports:
- iCLOCK  in  1  system clock.
- inRESET  in  1  asynchronous active-low reset.
- iREMOVE  in  1  synchronous flush (pipeline cancel).
- iPREVIOUS_VALID  in  1  last latch holds a valid operation.
- oPREVIOUS_BUSY  out  1  collector cannot accept; upstream latches hold.
- iPREVIOUS_SIGN  in  1  operation is signed.
- iPREVIOUS_DIVISOR  in  32  original divisor.
- iPREVIOUS_DIVIDEND  in  32  original dividend.
- iPREVIOUS_Q  in  32  magnitude quotient.
- iPREVIOUS_R  in  32  magnitude remainder.
- oDATA_VALID  out  1  result available.
- iDATA_BUSY  in  1  consumer stall.
- oDATA_Q  out  32  final quotient.
- oDATA_R  out  32  final remainder.

Behaviour:
- Reset (inRESET low, async):
  - Pointers and count are 0; all FIFO entries are cleared.
  - oDATA_VALID=0, oDATA_Q=0, oDATA_R=0, oPREVIOUS_BUSY=0.
- Push: iPREVIOUS_VALID && !full on a rising edge writes the corrected result at wptr; wptr+1 wraps modulo DEPTH.
- Pop: oDATA_VALID && !iDATA_BUSY advances rptr modulo DEPTH.
- Count and pointers:
  - count is PTR_W+1 bits.
  - push only: +1; pop only: -1; push and pop together: unchanged.
- Full/empty flags:
  - full = (count==DEPTH); empty = (count==0).
  - oPREVIOUS_BUSY = full. It is a registered-state function with no combinational path from iDATA_BUSY.
  - At full, a same-cycle pop does not enable a push; busy drops the cycle after the pop.
- Output timing:
  - oDATA_VALID = !empty.
  - oDATA_Q/oDATA_R = entry[rptr] when not empty, else 0.
  - Latency: a push at edge N makes the result visible after edge N (one cycle).
- Correction (combinational, before the write):
  - dz = (divisor==0).
  - If dz: Q=32'hFFFFFFFF and R=dividend, regardless of sign.
  - Else if SIGN: Q negated (two's complement) when dividend[31]^divisor[31]; R negated when dividend[31].
  - Else: Q and R pass unchanged.
  - Signed overflow (0x80000000 / -1) is not special-cased: Q=0x80000000, R=0, as the magnitude path delivers.
- iREMOVE:
  - Count and pointers go to 0 and oDATA_VALID drops the next cycle.
  - iREMOVE has priority over a simultaneous push or pop; entry contents need not be cleared.
- Reset mid-operation discards everything immediately (async).
- Contract: upstream presents no valid data when busy; the collector ignores iPREVIOUS_VALID while full.

Optional Feature:
- Macro: DIV_PIPELINED_COLLECTOR_DIVZERO_FLAG_EN.
- Defined:
  - Each entry stores a dz bit.
  - Adds output port oDATA_DIVZERO (1 bit) = stored dz of entry[rptr], 0 when empty; reset value 0.
- Undefined: no port and no storage bit; the result values for divide-by-zero are identical in both builds.

Decomposition:
- Shared package div_pkg: DIV_WIDTH=32; DIV_DZ_QUOTIENT=32'hFFFFFFFF; result struct {q, r, dz}.
- One sub-module, div_sign_fixup: combinational correction; inputs sign/divisor/dividend/q/r, outputs q/r/dz.
- The FIFO stays inline.

Test Plan:
- Unsigned 100/7 (Q=14, R=2 raw, SIGN=0), iDATA_BUSY=0 -> next cycle oDATA_VALID=1, Q=14, R=2; pops the following cycle.
- Signed -100/7 (raw Q=14, R=2, SIGN=1) -> Q=0xFFFFFFF2, R=0xFFFFFFFE; signed 100/-7 -> Q=0xFFFFFFF2, R=2.
- Divisor 0, dividend 0x12345678, either sign -> Q=0xFFFFFFFF, R=0x12345678; oDATA_DIVZERO=1 when the macro is defined.
- iDATA_BUSY=1, push 3 ops back-to-back with DEPTH=2:
  - oPREVIOUS_BUSY rises after the 2nd push; the 3rd is held upstream.
  - Releasing busy drains in order; busy falls one cycle after the first pop.
- FIFO holding 2 entries, iREMOVE=1 with simultaneous push -> next cycle oDATA_VALID=0, oPREVIOUS_BUSY=0, count 0; the pushed op is discarded.
- Assert inRESET low asynchronously mid-stream with 1 entry pending -> outputs 0 immediately; after release, a new op completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the pipelined divider tail stage.
//   DIV_WIDTH        operand/result width
//   DIV_DZ_QUOTIENT  quotient returned for a zero divisor
//   div_result_t     corrected result {q, r, dz}
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [DIV_WIDTH-1:0] q;
      logic [DIV_WIDTH-1:0] r;
      logic                 dz;
   } div_result_t;

endpackage

// File: rtl/div_pipelined_collector_if.sv
// div_pipelined_collector_if: upstream latch handshake plus writeback handshake.
//   slave  : collector view (accepts iPREVIOUS_*, drives oPREVIOUS_BUSY and oDATA_*)
//   master : environment view (drives iPREVIOUS_* and iDATA_BUSY)
// Optional: DIV_PIPELINED_COLLECTOR_DIVZERO_FLAG_EN adds oDATA_DIVZERO.
interface div_pipelined_collector_if;
   import div_pkg::*;

   logic                 iPREVIOUS_VALID;
   logic                 oPREVIOUS_BUSY;
   logic                 iPREVIOUS_SIGN;
   logic [DIV_WIDTH-1:0] iPREVIOUS_DIVISOR;
   logic [DIV_WIDTH-1:0] iPREVIOUS_DIVIDEND;
   logic [DIV_WIDTH-1:0] iPREVIOUS_Q;
   logic [DIV_WIDTH-1:0] iPREVIOUS_R;
   logic                 oDATA_VALID;
   logic                 iDATA_BUSY;
   logic [DIV_WIDTH-1:0] oDATA_Q;
   logic [DIV_WIDTH-1:0] oDATA_R;
`ifdef DIV_PIPELINED_COLLECTOR_DIVZERO_FLAG_EN
   logic                 oDATA_DIVZERO;

   modport slave (
      input  iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND,
             iPREVIOUS_Q, iPREVIOUS_R, iDATA_BUSY,
      output oPREVIOUS_BUSY, oDATA_VALID, oDATA_Q, oDATA_R, oDATA_DIVZERO
   );
   modport master (
      output iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND,
             iPREVIOUS_Q, iPREVIOUS_R, iDATA_BUSY,
      input  oPREVIOUS_BUSY, oDATA_VALID, oDATA_Q, oDATA_R, oDATA_DIVZERO
   );
`else
   modport slave (
      input  iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND,
             iPREVIOUS_Q, iPREVIOUS_R, iDATA_BUSY,
      output oPREVIOUS_BUSY, oDATA_VALID, oDATA_Q, oDATA_R
   );
   modport master (
      output iPREVIOUS_VALID, iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND,
             iPREVIOUS_Q, iPREVIOUS_R, iDATA_BUSY,
      input  oPREVIOUS_BUSY, oDATA_VALID, oDATA_Q, oDATA_R
   );
`endif

endinterface

// File: rtl/div_sign_fixup.sv
// div_sign_fixup: turns the magnitude quotient/remainder into the final result.
//   sign, divisor, dividend : original operation
//   q, r                    : magnitude results from the divider core
//   q_fix, r_fix, dz        : corrected results and divide-by-zero flag
// Quotient sign follows the XOR of operand signs, remainder follows the dividend.
module div_sign_fixup
   import div_pkg::*;
(
   input  logic                 sign,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] q,
   input  logic [DIV_WIDTH-1:0] r,
   output logic [DIV_WIDTH-1:0] q_fix,
   output logic [DIV_WIDTH-1:0] r_fix,
   output logic                 dz
);

   always_comb begin
      dz    = (divisor == '0);
      q_fix = q;
      r_fix = r;
      if (dz) begin
         q_fix = DIV_DZ_QUOTIENT;
         r_fix = dividend;
      end else if (sign) begin
         if (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]) q_fix = -q;
         if (dividend[DIV_WIDTH-1])                        r_fix = -r;
      end
   end

endmodule

// File: rtl/div_pipelined_collector.sv
// div_pipelined_collector: tail of the pipelined divider. Corrects the raw
// magnitude result and buffers it in a DEPTH-entry FIFO for writeback.
//   iCLOCK   system clock
//   inRESET  asynchronous active-low reset
//   iREMOVE  synchronous pipeline flush (wins over push and pop)
//   bus      slave side of div_pipelined_collector_if
// Optional: DIV_PIPELINED_COLLECTOR_DIVZERO_FLAG_EN stores a dz bit per entry
// and presents it on oDATA_DIVZERO.
module div_pipelined_collector
   import div_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic iCLOCK,
   input  logic inRESET,
   input  logic iREMOVE,
   div_pipelined_collector_if.slave bus
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DIV_WIDTH-1:0] mem_q [DEPTH];
   logic [DIV_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     rptr;
   logic [PTR_W:0]       count;

   logic [DIV_WIDTH-1:0] fix_q;
   logic [DIV_WIDTH-1:0] fix_r;
   logic                 fix_dz;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;

   div_sign_fixup u_fixup (
      .sign     (bus.iPREVIOUS_SIGN),
      .divisor  (bus.iPREVIOUS_DIVISOR),
      .dividend (bus.iPREVIOUS_DIVIDEND),
      .q        (bus.iPREVIOUS_Q),
      .r        (bus.iPREVIOUS_R),
      .q_fix    (fix_q),
      .r_fix    (fix_r),
      .dz       (fix_dz)
   );

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // Push is gated by full only, so a pop at full never frees the slot in the same cycle.
   assign push  = bus.iPREVIOUS_VALID && !full;
   assign pop   = !empty && !bus.iDATA_BUSY;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
            mem_r[i] <= '0;
         end
      end else if (iREMOVE) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem_q[wptr] <= fix_q;
            mem_r[wptr] <= fix_r;
            wptr        <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.oPREVIOUS_BUSY = full;
   assign bus.oDATA_VALID    = !empty;
   assign bus.oDATA_Q        = empty ? '0 : mem_q[rptr];
   assign bus.oDATA_R        = empty ? '0 : mem_r[rptr];

`ifdef DIV_PIPELINED_COLLECTOR_DIVZERO_FLAG_EN
   logic mem_dz [DEPTH];

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         for (int i = 0; i < DEPTH; i++) mem_dz[i] <= 1'b0;
      end else if (!iREMOVE && push) begin
         mem_dz[wptr] <= fix_dz;
      end
   end

   assign bus.oDATA_DIVZERO = empty ? 1'b0 : mem_dz[rptr];
`else
   // Results for a zero divisor are already encoded in q/r; the flag itself is not kept.
   logic unused_dz;
   assign unused_dz = fix_dz;
`endif

endmodule
